io_ports: RTL
=============

IO_PORTS -- requirements
Module: io_ports

Interface
REQ-001 The block SHALL have parameter PORT_COUNT, default 3, meaning the number of I/O ports (B, C, D, ...), legal range 1..16.
REQ-002 The block SHALL have parameter PORT_WIDTH, default 8, meaning the pins per port, legal range 1..8.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth, legal range 2..4.
REQ-004 The block SHALL have port clock, input, 1, system clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 The block SHALL have port addr, input, 8, I/O register address.
REQ-007 The block SHALL have port write_en, input, 1, write strobe, qualifying addr and write_data for one cycle.
REQ-008 The block SHALL have port write_data, input, 8, write data; bits above PORT_WIDTH are ignored.
REQ-009 The block SHALL have port read_data, output, 8, registered read data, zero-extended.
REQ-010 The block SHALL have port pins_in, input, PORT_COUNT*PORT_WIDTH, asynchronous pin levels; port p occupies slice p.
REQ-011 The block SHALL have port pins_out, output, PORT_COUNT*PORT_WIDTH, driven pin levels.
REQ-012 The block SHALL have port pins_oe, output, PORT_COUNT*PORT_WIDTH, output enable per pin.
REQ-013 The block SHALL have port irq, output, 1, pin-change interrupt request; it exists only with IO_PCINT_EN.

Function
REQ-014 Port p registers SHALL decode as: PINx at 3p, PORTx at 3p+1, DDRx at 3p+2 (defaults: PINB=0x00 ... DDRD=0x08).
REQ-015 A read SHALL return the addressed value on read_data on the clock edge after addr is presented (1-cycle latency); read_data SHALL hold between reads.
REQ-016 Reading PINx SHALL return the synchronised pin value (SYNC_STAGES flops), regardless of DDRx.
REQ-017 Writing PORTx or DDRx SHALL take effect on pins_out and pins_oe on the next clock edge.
REQ-018 Writing PINx SHALL toggle every PORTx bit written as 1 and leave bits written as 0 unchanged.
REQ-019 pins_oe SHALL equal DDRx; pins_out SHALL equal PORTx AND DDRx.
REQ-020 Unmapped addresses SHALL read 0x00, and writes to them SHALL be ignored without side effects.
REQ-021 A read and a write to the same register in the same cycle SHALL return the pre-write value.

Reset
REQ-022 While reset_n=0, PORTx, DDRx, the synchroniser flops, read_data, pins_out and pins_oe SHALL be 0.
REQ-023 While reset_n=0, PCMSKx, PCIFR, irq and the priming counter SHALL be 0.
REQ-024 Reset asserted mid-access SHALL abort the access; no partial write SHALL persist.

Configuration
REQ-025 Macro IO_PCINT_EN SHALL, when defined, add pin-change interrupt logic.
REQ-026 With IO_PCINT_EN, PCMSKx for port p SHALL sit at 3*PORT_COUNT+p (default 0x09..0x0B), and PCIFR at 4*PORT_COUNT (default 0x0C), with bit p assigned to port p.
REQ-027 With IO_PCINT_EN, the PCIFR bit for port p SHALL set when (sync XOR previous sync) AND PCMSKx is non-zero.
REQ-028 With IO_PCINT_EN, writing 1 to a PCIFR bit SHALL clear it; when a set and a clear coincide, the set SHALL win.
REQ-029 With IO_PCINT_EN, irq SHALL be the registered OR of PCIFR.
REQ-030 With IO_PCINT_EN, a priming counter SHALL suppress flag setting for SYNC_STAGES+1 cycles after reset release.
REQ-031 Without IO_PCINT_EN, the irq port and the PCMSKx/PCIFR addresses SHALL be absent, and those addresses SHALL be unmapped.

Structure
REQ-032 Package def SHALL hold the offsets PIN_OFFSET=0, PORT_OFFSET=1 and DDR_OFFSET=2, the PCMSK/PCIFR base formulas, and the existing PINB..DDRD constants.
REQ-033 Sub-module io_sync SHALL implement one parametrised SYNC_STAGES-deep bit-vector synchroniser with async active-low reset; it is instantiated once per port.

Verification
REQ-034 The bench SHALL cover: write DDRB=0xFF, PORTB=0xA5 -> pins_oe[7:0]=0xFF, pins_out[7:0]=0xA5 one cycle later.
REQ-035 The bench SHALL cover: with PORTB=0xA5, write PINB=0x0F -> PORTB reads 0xAA.
REQ-036 The bench SHALL cover: drive pins_in port C=0x3C, wait SYNC_STAGES+1 cycles, read 0x03 -> read_data=0x3C; a read at address 0x20 -> 0x00.
REQ-037 The bench SHALL cover, with IO_PCINT_EN: PCMSKD=0x01, toggle pin D0 -> PCIFR bit 2 set and irq=1; write PCIFR=0x04 -> irq=0.
REQ-038 The bench SHALL cover, with IO_PCINT_EN: a masked pin change in the same cycle as a PCIFR clear write -> the flag remains 1.
REQ-039 The bench SHALL cover: reset_n pulsed low mid-write -> all registers 0, and no interrupt flag is raised within SYNC_STAGES+1 cycles after release with pins_in held at 0xFF.

Source files
------------

// File: rtl/io_ports_pkg.sv
// -----------------------------------------------------------------------------
// def -- shared constants for the io_ports register file.
//
// Each I/O port owns three consecutive byte addresses: PINx (synchronised pin
// levels), PORTx (output latch) and DDRx (direction, 1 = drive). The optional
// pin-change interrupt block (macro IO_PCINT_EN) places one PCMSKx register
// per port after the port registers, followed by a single PCIFR flag register.
// -----------------------------------------------------------------------------
package def;

    localparam int REGS_PER_PORT = 3;
    localparam int PIN_OFFSET    = 0;
    localparam int PORT_OFFSET   = 1;
    localparam int DDR_OFFSET    = 2;

    // Addresses for the default three-port build (B, C, D).
    localparam logic [7:0] PINB  = 8'h00;
    localparam logic [7:0] PORTB = 8'h01;
    localparam logic [7:0] DDRB  = 8'h02;
    localparam logic [7:0] PINC  = 8'h03;
    localparam logic [7:0] PORTC = 8'h04;
    localparam logic [7:0] DDRC  = 8'h05;
    localparam logic [7:0] PIND  = 8'h06;
    localparam logic [7:0] PORTD = 8'h07;
    localparam logic [7:0] DDRD  = 8'h08;

    // PCMSKx for port p sits directly after the last DDR register.
    function automatic int pcmsk_addr(input int port_count, input int p);
        return REGS_PER_PORT * port_count + p;
    endfunction

    // PCIFR follows the last PCMSK register.
    function automatic int pcifr_addr(input int port_count);
        return (REGS_PER_PORT + 1) * port_count;
    endfunction

endpackage

// File: rtl/io_ports_sync.sv
// -----------------------------------------------------------------------------
// io_sync -- STAGES-deep flop chain that brings an asynchronous bit vector
// into the clock domain. All stages clear on the asynchronous active-low reset.
//
// Ports:
//   clock    system clock (rising edge)
//   reset_n  asynchronous active-low reset
//   d_i      asynchronous input vector
//   q_o      synchronised output vector (last stage)
// -----------------------------------------------------------------------------
module io_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_ports.sv
// -----------------------------------------------------------------------------
// io_ports -- byte-addressed GPIO register file with PORT_COUNT ports of
// PORT_WIDTH pins each.
//
// Per port p: PINx at 3p (read synchronised pins; writing toggles PORTx bits),
// PORTx at 3p+1, DDRx at 3p+2. pins_oe = DDRx, pins_out = PORTx & DDRx.
// Reads are registered: read_data shows the register addressed in the previous
// cycle, sampled before any same-cycle write lands. Unmapped addresses read 0.
//
// Optional feature, macro IO_PCINT_EN: pin-change interrupts. PCMSKx at
// 3*PORT_COUNT+p, PCIFR at 4*PORT_COUNT (bit p = port p, write 1 to clear,
// set beats clear), irq = registered OR of PCIFR. Without the macro the irq
// port does not exist and those addresses are unmapped.
//
// Ports:
//   clock        system clock (rising edge)
//   reset_n      asynchronous active-low reset
//   addr         register address
//   write_en     write strobe for addr / write_data
//   write_data   write data (bits above PORT_WIDTH ignored)
//   read_data    registered read data, zero-extended
//   pins_in      asynchronous pin levels, port p in slice p
//   pins_out     driven pin levels
//   pins_oe      per-pin output enable
//   irq          pin-change interrupt request (IO_PCINT_EN only)
// -----------------------------------------------------------------------------
module io_ports
    import def::*;
#(
    parameter int PORT_COUNT  = 3,
    parameter int PORT_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [7:0]                       addr,
    input  logic                             write_en,
    input  logic [7:0]                       write_data,
    output logic [7:0]                       read_data,
    input  logic [PORT_COUNT*PORT_WIDTH-1:0] pins_in,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pins_out,
    output logic [PORT_COUNT*PORT_WIDTH-1:0] pins_oe
`ifdef IO_PCINT_EN
    ,
    output logic                             irq
`endif
);

    localparam int NPINS = PORT_COUNT * PORT_WIDTH;

    logic [NPINS-1:0]      sync_w;
    logic [NPINS-1:0]      port_q, port_d;
    logic [NPINS-1:0]      ddr_q, ddr_d;
    logic [7:0]            rd_q, rd_d;
    logic [PORT_WIDTH-1:0] wdata;

    assign wdata = write_data[PORT_WIDTH-1:0];

    for (genvar g = 0; g < PORT_COUNT; g++) begin : g_sync
        io_sync #(
            .WIDTH  (PORT_WIDTH),
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clock   (clock),
            .reset_n (reset_n),
            .d_i     (pins_in[g*PORT_WIDTH +: PORT_WIDTH]),
            .q_o     (sync_w[g*PORT_WIDTH +: PORT_WIDTH])
        );
    end

`ifdef IO_PCINT_EN
    // Priming counter saturates at SYNC_STAGES+1; until then the synchroniser
    // is still flushing post-reset values and edges are not trusted.
    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [NPINS-1:0]      pcmsk_q, pcmsk_d;
    logic [NPINS-1:0]      prev_q;
    logic [PORT_COUNT-1:0] pcifr_q, pcifr_d, pc_set, pc_clr;
    logic [2:0]            prime_q;
    logic                  irq_q;
`endif

    always_comb begin
        port_d = port_q;
        ddr_d  = ddr_q;
        rd_d   = '0;
`ifdef IO_PCINT_EN
        pcmsk_d = pcmsk_q;
        pc_set  = '0;
        pc_clr  = '0;
`endif
        for (int p = 0; p < PORT_COUNT; p++) begin
            if (addr == 8'(REGS_PER_PORT*p + PIN_OFFSET)) begin
                rd_d = 8'(sync_w[p*PORT_WIDTH +: PORT_WIDTH]);
                if (write_en) begin
                    port_d[p*PORT_WIDTH +: PORT_WIDTH] = port_q[p*PORT_WIDTH +: PORT_WIDTH] ^ wdata;
                end
            end
            if (addr == 8'(REGS_PER_PORT*p + PORT_OFFSET)) begin
                rd_d = 8'(port_q[p*PORT_WIDTH +: PORT_WIDTH]);
                if (write_en) begin
                    port_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                end
            end
            if (addr == 8'(REGS_PER_PORT*p + DDR_OFFSET)) begin
                rd_d = 8'(ddr_q[p*PORT_WIDTH +: PORT_WIDTH]);
                if (write_en) begin
                    ddr_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                end
            end
`ifdef IO_PCINT_EN
            if (addr == 8'(pcmsk_addr(PORT_COUNT, p))) begin
                rd_d = 8'(pcmsk_q[p*PORT_WIDTH +: PORT_WIDTH]);
                if (write_en) begin
                    pcmsk_d[p*PORT_WIDTH +: PORT_WIDTH] = wdata;
                end
            end
            pc_set[p] = (prime_q == PRIME_DONE) &&
                        (|((sync_w[p*PORT_WIDTH +: PORT_WIDTH] ^ prev_q[p*PORT_WIDTH +: PORT_WIDTH])
                           & pcmsk_q[p*PORT_WIDTH +: PORT_WIDTH]));
`endif
        end
`ifdef IO_PCINT_EN
        if (addr == 8'(pcifr_addr(PORT_COUNT))) begin
            rd_d = 8'(pcifr_q);
            if (write_en) begin
                pc_clr = PORT_COUNT'(write_data);
            end
        end
        // Set is OR-ed in after the clear so a coinciding edge is never lost.
        pcifr_d = (pcifr_q & ~pc_clr) | pc_set;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            port_q <= '0;
            ddr_q  <= '0;
            rd_q   <= '0;
`ifdef IO_PCINT_EN
            pcmsk_q <= '0;
            prev_q  <= '0;
            pcifr_q <= '0;
            prime_q <= '0;
            irq_q   <= 1'b0;
`endif
        end else begin
            port_q <= port_d;
            ddr_q  <= ddr_d;
            rd_q   <= rd_d;
`ifdef IO_PCINT_EN
            pcmsk_q <= pcmsk_d;
            prev_q  <= sync_w;
            pcifr_q <= pcifr_d;
            if (prime_q != PRIME_DONE) begin
                prime_q <= prime_q + 3'd1;
            end
            irq_q <= |pcifr_q;
`endif
        end
    end

    assign read_data = rd_q;
    assign pins_oe   = ddr_q;
    assign pins_out  = port_q & ddr_q;
`ifdef IO_PCINT_EN
    assign irq = irq_q;
`endif

endmodule
